// File: rtl/read_empty_level.sv
// Read-domain pointer/flag controller for the async FIFO: write-pointer synchronizer,
// binary/Gray read pointer, registered empty/almost_empty/count. Optional sticky underflow under READ_EMPTY_UNDERFLOW_EN.
module read_empty_level #(
  parameter int ADDR_SIZE   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 read_clk,
  input  logic                 read_reset,
  input  logic                 read_inc,
  input  logic [ADDR_SIZE:0]   write_ptr,
  input  logic [ADDR_SIZE:0]   ae_level,
  input  logic                 underflow_clr,
  output logic [ADDR_SIZE-1:0] read_addr,
  output logic [ADDR_SIZE:0]   read_ptr,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   read_count,
  output logic                 underflow
);

  localparam int PW = ADDR_SIZE + 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("read_empty_level: SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0][PW-1:0] r_sync;
  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_gray;
  logic [PW-1:0] r_count;
  logic          r_empty;
  logic          r_almost_empty;

  logic [PW-1:0] w_wsync_gray;
  logic [PW-1:0] w_wsync_bin;
  logic          w_pop;
  logic [PW-1:0] w_next_bin;
  logic [PW-1:0] w_next_gray;
  logic [PW-1:0] w_cnt_next;

  // NOTE: the synchronizer chain is ordinary flops, not storage, so it is cleared
  // with everything else; otherwise a stale pointer could fake data after reset.
  always_ff @(posedge read_clk or negedge read_reset) begin
    if (!read_reset) r_sync <= '0;
    else             r_sync <= {r_sync[SYNC_STAGES-2:0], write_ptr};
  end

  assign w_wsync_gray = r_sync[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_wsync_bin = '0;
    for (int i = 0; i < PW; i++) begin
      w_wsync_bin[i] = ^(w_wsync_gray >> i);
    end
  end

  assign w_pop       = read_inc & ~r_empty;
  assign w_next_bin  = r_bin + {{ADDR_SIZE{1'b0}}, w_pop};
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);
  assign w_cnt_next  = w_wsync_bin - w_next_bin;

  // NOTE: state uses non-blocking assignments so all flags see the same pre-edge values.
  always_ff @(posedge read_clk or negedge read_reset) begin
    if (!read_reset) begin
      r_bin          <= '0;
      r_gray         <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      r_bin          <= w_next_bin;
      r_gray         <= w_next_gray;
      r_count        <= w_cnt_next;
      r_empty        <= (w_next_gray == w_wsync_gray);
      r_almost_empty <= (w_cnt_next <= ae_level);
    end
  end

  assign read_addr    = r_bin[ADDR_SIZE-1:0];
  assign read_ptr     = r_gray;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign read_count   = r_count;

`ifdef READ_EMPTY_UNDERFLOW_EN
  logic r_underflow;

  // Set has priority: a pop-while-empty on the clear edge keeps the flag.
  always_ff @(posedge read_clk or negedge read_reset) begin
    if (!read_reset)                r_underflow <= 1'b0;
    else if (read_inc && r_empty)   r_underflow <= 1'b1;
    else if (underflow_clr)         r_underflow <= 1'b0;
  end

  assign underflow = r_underflow;
`else
  logic w_unused_clr;
  assign w_unused_clr = underflow_clr;
  assign underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_read_empty_level.sv
// Bench for read_empty_level: directed scenarios plus randomized traffic against a
// word-count model of the read side (honours READ_EMPTY_UNDERFLOW_EN).
`timescale 1ns/1ps
module tb_read_empty_level;

  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
`ifdef READ_EMPTY_UNDERFLOW_EN
  localparam bit UF_ON = 1'b1;
`else
  localparam bit UF_ON = 1'b0;
`endif

  logic          read_clk = 1'b0;
  logic          read_reset;
  logic          read_inc;
  logic [PW-1:0] write_ptr;
  logic [PW-1:0] ae_level;
  logic          underflow_clr;
  logic [AW-1:0] read_addr;
  logic [PW-1:0] read_ptr;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] read_count;
  logic          underflow;

  read_empty_level #(.ADDR_SIZE(AW), .SYNC_STAGES(SS)) dut (
    .read_clk      (read_clk),
    .read_reset    (read_reset),
    .read_inc      (read_inc),
    .write_ptr     (write_ptr),
    .ae_level      (ae_level),
    .underflow_clr (underflow_clr),
    .read_addr     (read_addr),
    .read_ptr      (read_ptr),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .read_count    (read_count),
    .underflow     (underflow)
  );

  always #5 read_clk = ~read_clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: words written and words read as plain counts; the read side sees the
  // write count as it stood SS edges earlier.
  int m_w, m_rd, m_avail;
  bit m_empty, m_ae, m_uf;
  int sync_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic set_w(input int n);
    m_w       = n;
    write_ptr = to_gray(n);
  endtask

  task automatic check_model();
    check("read_addr",    read_addr,    m_rd % DEPTH);
    check("read_ptr",     read_ptr,     to_gray(m_rd));
    check("empty",        empty,        m_empty);
    check("almost_empty", almost_empty, m_ae);
    check("read_count",   read_count,   m_avail);
    check("underflow",    underflow,    m_uf);
  endtask

  task automatic step();
    int seen;
    bit pop;
    seen = sync_q.pop_front();
    sync_q.push_back(m_w);
    pop = read_inc && !m_empty;
    if (UF_ON) begin
      if (read_inc && m_empty) m_uf = 1'b1;
      else if (underflow_clr)  m_uf = 1'b0;
    end
    if (pop) m_rd++;
    m_avail = seen - m_rd;
    m_empty = (m_avail == 0);
    m_ae    = (m_avail <= int'(ae_level));
    @(posedge read_clk);
    #1;
    check_model();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then releases.
  task automatic do_reset(input int w_after);
    @(negedge read_clk);
    read_reset = 1'b0;
    #1;
    check("rst_read_addr",    read_addr,    0);
    check("rst_read_ptr",     read_ptr,     0);
    check("rst_empty",        empty,        1);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_read_count",   read_count,   0);
    check("rst_underflow",    underflow,    0);
    sync_q = {};
    repeat (SS) sync_q.push_back(0);
    m_rd = 0; m_avail = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
    read_inc = 1'b0;
    underflow_clr = 1'b0;
    set_w(w_after);
    @(negedge read_clk);
    read_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] exp_ptr [3];
    exp_ptr[0] = 5'b00001; exp_ptr[1] = 5'b00011; exp_ptr[2] = 5'b00010;
    read_reset = 1'b0; read_inc = 1'b0; underflow_clr = 1'b0;
    write_ptr = '0; ae_level = 5'd2;
    #3;

    // Build count=5 with a non-zero read address, then reset mid-stream.
    do_reset(7);
    repeat (3) step();
    check("fill7_count", read_count, 7);
    read_inc = 1'b1;
    repeat (2) step();
    read_inc = 1'b0;
    check("pre_rst_count", read_count, 5);
    check("pre_rst_addr",  read_addr,  2);

    // Sync latency: write_ptr = gray(3) held from reset.
    do_reset(3);
    step(); check("lat_edge1_empty", empty, 1);
    step(); check("lat_edge2_empty", empty, 1);
    step();
    check("lat_edge3_empty", empty, 0);
    check("lat_edge3_count", read_count, 3);
    check("lat_edge3_ae",    almost_empty, 0);

    // Drain three words.
    read_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("drain_addr",  read_addr,  i + 1);
      check("drain_ptr",   read_ptr,   exp_ptr[i]);
      check("drain_count", read_count, 2 - i);
      check("drain_ae",    almost_empty, 1);
      check("drain_empty", empty, (i == 2) ? 1 : 0);
    end

    // Pop while empty, hold, clear alone, clear together with pop-while-empty.
    step();
    check("uf_addr_hold", read_addr, 3);
    check("uf_set",       underflow, UF_ON);
    read_inc = 1'b0;
    step();
    check("uf_held",      underflow, UF_ON);
    underflow_clr = 1'b1;
    step();
    check("uf_clr",       underflow, 0);
    read_inc = 1'b1;
    step();
    check("uf_set_wins",  underflow, UF_ON);
    check("uf_addr_hold2", read_addr, 3);
    read_inc = 1'b0; underflow_clr = 1'b0;

    // Full FIFO and wrap-around of the read pointer.
    do_reset(16);
    repeat (3) step();
    check("full_count", read_count, 16);
    check("full_empty", empty, 0);
    read_inc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) check("wrap_addr15", read_addr, 15);
    end
    read_inc = 1'b0;
    check("wrap_addr0", read_addr, 0);
    check("wrap_ptr",   read_ptr, 5'b11000);
    check("wrap_empty", empty, 1);
    check("wrap_count", read_count, 0);

    // Randomized traffic, including thresholds above the depth.
    do_reset(0);
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) ae_level = PW'($urandom_range(0, 20));
      if ((m_w - m_rd) < DEPTH && $urandom_range(0, 1) == 1) set_w(m_w + 1);
      read_inc      = ($urandom_range(0, 1) == 1);
      underflow_clr = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
